// File: rtl/horner_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package horner_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        COEF = 3'd1,
        MUL  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Width of a degree field able to hold 0..max_deg (never narrower than one bit).
    function automatic int unsigned deg_width(input int unsigned max_deg);
        return (max_deg < 1) ? 1 : $clog2(max_deg + 1);
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Pipelined full-width unsigned multiplier with a valid shift register.
module mul_pipe #(
    parameter int unsigned W          = 32,
    parameter int unsigned MUL_STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   prod,
    output logic             out_valid
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0]         stage_q [MUL_STAGES];
    logic [MUL_STAGES-1:0] vld_q;

    // First stage forms the product, later stages only delay it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                stage_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            stage_q[0] <= PW'(a) * PW'(b);
            vld_q[0]   <= in_valid;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
                vld_q[i]   <= vld_q[i-1];
            end
        end
    end

    assign prod      = stage_q[MUL_STAGES-1];
    assign out_valid = vld_q[MUL_STAGES-1];

endmodule

// File: rtl/horner_eval.sv
// Sequential Horner evaluator: acc = acc*x + c_k, coefficients highest-order first,
// with valid/ready streams on start, coefficient and result sides.
module horner_eval
    import horner_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter int unsigned MAX_DEG    = 15,
    parameter int unsigned MUL_STAGES = 1,
    localparam int unsigned DW        = deg_width(MAX_DEG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [W-1:0]  start_x,
    input  logic [DW-1:0] start_deg,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [W-1:0]  coef,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res,
    output logic          res_ovf,
    output logic          busy
);

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, acc_q, coef_q;
    logic [DW-1:0]   cnt_q, deg_sat;
    logic            ovf_q, ovf_new;
    logic            start_xfer, coef_xfer, mul_go;
    logic [2*W-1:0]  prod;
    logic            prod_valid;
    logic [W:0]      sum;

    assign start_xfer = start_valid & start_ready;
    assign coef_xfer  = coef_valid & coef_ready;
    assign deg_sat    = (32'(start_deg) > MAX_DEG) ? DW'(MAX_DEG) : start_deg;
    assign sum        = {1'b0, prod[W-1:0]} + {1'b0, coef_q};
    assign ovf_new    = ovf_q | (|prod[2*W-1:W]) | sum[W];

    mul_pipe #(
        .W          (W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_go),
        .a         (acc_q),
        .b         (x_q),
        .prod      (prod),
        .out_valid (prod_valid)
    );

    // Next-state decode; the multiplier is launched on the coefficient transfer.
    always_comb begin
        state_d = state_q;
        mul_go  = 1'b0;
        case (state_q)
            IDLE: if (start_xfer) state_d = COEF;
            COEF: begin
                if (coef_xfer) begin
                    state_d = MUL;
                    mul_go  = 1'b1;
                end
            end
            MUL:  if (prod_valid) state_d = ADD;
            ADD:  state_d = (cnt_q == '0) ? DONE : COEF;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_ready <= 1'b1;
            coef_ready  <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_ready <= (state_d == IDLE);
            coef_ready  <= (state_d == COEF);
            res_valid   <= (state_d == DONE);
            busy        <= (state_d != IDLE);
        end
    end

    // Accumulator, counter and sticky overflow; result captured on the final add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            acc_q   <= '0;
            coef_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            res     <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (start_xfer) begin
                x_q   <= start_x;
                cnt_q <= deg_sat;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
            if (coef_xfer) begin
                coef_q <= coef;
            end
            if (state_q == ADD) begin
                acc_q <= sum[W-1:0];
                ovf_q <= ovf_new;
                if (cnt_q == '0) begin
                    res     <= sum[W-1:0];
                    res_ovf <= ovf_new;
                end else begin
                    cnt_q <= cnt_q - DW'(1);
                end
            end
        end
    end

endmodule

// File: doc/horner_eval.md
Name: horner_eval

Overview:
Parametrised sequential Horner polynomial evaluator. It computes p(x) = c_n*x^n + ... + c_0 as acc = acc*x + c_k, consuming coefficients highest-order first over a valid/ready stream. It replaces the fixed 32-bit multiply/add flop pair with a generic-width block that has a configurable multiplier pipeline depth, flow control and an overflow flag. It sits between a coefficient source (ROM/FIFO) and a result consumer.

Parameters:
W, 32, datapath width of x, coefficients and result (>=2)
MAX_DEG, 15, maximum polynomial degree accepted
MUL_STAGES, 1, register stages inside the multiplier (>=1)
DW, $clog2(MAX_DEG+1), degree field width (derived localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start_valid  in  1  request a new evaluation
start_ready  out  1  block idle, accepts start
start_x  in  W  evaluation point x
start_deg  in  DW  degree n; values > MAX_DEG saturate to MAX_DEG
coef_valid  in  1  coefficient available
coef_ready  out  1  block accepts a coefficient this cycle
coef  in  W  coefficient, c_n first, c_0 last
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res  out  W  p(x) mod 2^W
res_ovf  out  1  sticky: any intermediate exceeded W bits in this evaluation
busy  out  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low. While reset is low: state=IDLE, acc=0, res=0, res_valid=0, res_ovf=0, coef_ready=0, busy=0, start_ready=1 (decoded from IDLE). Assertion mid-evaluation aborts immediately. A partial result is never emitted.
- Handshakes: a transfer occurs on a rising edge where valid&&ready. Ready outputs are decoded from state only and never depend on the matching valid.
- Unsigned arithmetic throughout. The product is full 2W bits. acc_next = low W bits of (prod[W-1:0] + coef).
- States:
  IDLE: start_ready=1. On start transfer: latch x and degree n (saturated), set cnt=n, acc=0, ovf=0, go to COEF.
  COEF: coef_ready=1. On coef transfer: latch coef, launch acc*x into the multiplier, go to MUL. With no transfer, stay.
  MUL: wait MUL_STAGES cycles for the product, then go to ADD.
  ADD: acc <= prod[W-1:0] + coef_latched. ovf |= (prod[2W-1:W] != 0) | carry-out. If cnt==0 go to DONE, else cnt-1 and go to COEF.
  DONE: res_valid=1, res=acc and res_ovf=ovf, held stable until res_ready. On transfer go to IDLE.
- The first iteration computes 0*x + c_n = c_n. No special case.
- Throughput: one coefficient per MUL_STAGES+2 cycles when coef_valid is continuous. With continuous coefficients, res_valid rises exactly (n+1)*(MUL_STAGES+2) cycles after the start-transfer edge.
- Exactly n+1 coefficients are consumed per evaluation. coef_valid outside COEF is ignored. start_valid outside IDLE is ignored.
- res_ready high while in IDLE/COEF/MUL/ADD has no effect.
- res, res_ovf and acc hold their values until the next start transfer.

Decomposition:
- Shared package horner_pkg: state enum (IDLE, COEF, MUL, ADD, DONE) and the degree-width function.
- One sub-module, mul_pipe #(W, MUL_STAGES): full 2W-bit registered product with a shift-register valid. It has the same clk and reset.
- The FSM, counter, accumulator and overflow logic live in horner_eval.

Test Plan:
1. W=32, MUL_STAGES=1. x=5, n=2, coefs 3,2,1 streamed back to back -> res=86, res_ovf=0. res_valid rises 9 cycles after the start edge.
2. n=0, coef=0xDEADBEEF, x=0x12345678 -> res=0xDEADBEEF, res_ovf=0, after 3 cycles.
3. x=0x00010000, n=2, coefs 1,0,0 -> final product is 2^32, so res=0x00000000, res_ovf=1. A following evaluation with x=2, n=1, coefs 1,1 -> res=3, res_ovf=0 (flag cleared).
4. Backpressure: coef_valid gapped 0-4 cycles between coefficients, res_ready held low 6 cycles. Check that res and res_ovf stay stable, start_ready=0 until the result transfer, and no extra coefficient is consumed.
5. Pull reset low during MUL of the 2nd coefficient. All outputs are at reset values asynchronously, start_ready=1 after release. Then rerun scenario 1 -> res=86.
6. MUL_STAGES=3, start_deg=MAX_DEG+1 (non-power-of-two MAX_DEG=10). The degree saturates to 10, exactly 11 coefficients are consumed, and res_valid rises 55 cycles after the start edge.
